// File: rtl/i2s_tx.sv
// I2S master transmitter.
// Divides clk down to a bit clock, generates word select, and serializes one
// DATA_W-bit left/right sample pair per frame, MSB first, with the standard
// I2S one-bit delay after each word-select change. All outputs are registered.
//
// Sample write interface: wrt is a single-cycle strobe with no back-pressure.
// The pair on lft_in/rght_in is captured into the holding register on every
// cycle in which wrt is high; the last write before a frame load wins.
// smpl_req pulses for one cycle when the holding register is consumed.
module i2s_tx #(
  parameter int SCLK_DIV = 16,  // clk cycles per I2S_sclk half-period, >= 2
  parameter int SLOT_W   = 32,  // I2S_sclk periods per channel slot
  parameter int DATA_W   = 24   // sample width, < SLOT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rght_in,
  input  logic              wrt,
  output logic              smpl_req,
  output logic              underrun,
  input  logic              clr_undr,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_W);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   hold_l;
  logic [DATA_W-1:0]   hold_r;
  logic                hold_vld;
  logic                primed;   // first frame load after reset has happened
  logic [2*DATA_W-1:0] shifter;  // {left, right}, consumed MSB first

  logic             fall_evt;
  logic             frame_load;
  logic [BIT_W-1:0] bit_nxt;
  logic             ws_nxt;
  logic [BIT_W-1:0] k_nxt;
  logic             data_win;

  // Bit clock falls on the terminal count while it is currently high.
  assign fall_evt   = (div_cnt == DIV_TC) && I2S_sclk;
  assign frame_load = fall_evt && (bit_cnt == BIT_LAST);
  assign bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign ws_nxt     = (bit_nxt >= SLOT_LEN);
  // Bit position within the slot that starts at this falling edge.
  assign k_nxt      = ws_nxt ? (bit_nxt - SLOT_LEN) : bit_nxt;
  // k=0 is the one-bit delay pad, k>DATA_W is trailing zero fill.
  assign data_win   = (k_nxt != '0) && (k_nxt <= DATA_LEN);

  // Clock divider: toggle the bit clock every SCLK_DIV clk cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      I2S_sclk <= 1'b0;
    end else if (div_cnt == DIV_TC) begin
      div_cnt  <= '0;
      I2S_sclk <= ~I2S_sclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Bit counter and word select advance on each bit-clock falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= BIT_LAST;
      I2S_ws  <= 1'b1;
    end else if (fall_evt) begin
      bit_cnt <= bit_nxt;
      I2S_ws  <= ws_nxt;
    end
  end

  // Serializer: load the pair at frame start, shift one bit per data slot bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter  <= '0;
      I2S_data <= 1'b0;
    end else if (frame_load) begin
      shifter  <= {hold_l, hold_r};
      I2S_data <= 1'b0;
    end else if (fall_evt) begin
      if (data_win) begin
        I2S_data <= shifter[2*DATA_W-1];
        shifter  <= shifter << 1;
      end else begin
        I2S_data <= 1'b0;
      end
    end
  end

  // Holding register: a write always wins over the consume at frame load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_l   <= '0;
      hold_r   <= '0;
      hold_vld <= 1'b0;
    end else if (wrt) begin
      hold_l   <= lft_in;
      hold_r   <= rght_in;
      hold_vld <= 1'b1;
    end else if (frame_load) begin
      hold_vld <= 1'b0;
    end
  end

  // Frame status: request pulse, and sticky underrun where a new event beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_req <= 1'b0;
      primed   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      smpl_req <= frame_load;
      if (frame_load) begin
        primed <= 1'b1;
      end
      if (frame_load && !hold_vld && primed) begin
        underrun <= 1'b1;
      end else if (clr_undr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed testbench for i2s_tx with default parameters
// (SCLK_DIV=16, SLOT_W=32, DATA_W=24, frame period 2048 clk).
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] lft_in = '0;
  logic [23:0] rght_in = '0;
  logic        wrt = 1'b0;
  logic        clr_undr = 1'b0;
  logic        smpl_req;
  logic        underrun;
  logic        I2S_sclk;
  logic        I2S_ws;
  logic        I2S_data;

  int checks = 0;
  int errors = 0;
  int cyc;       // posedges since reset release
  int last_req;  // cyc of most recent smpl_req

  logic [47:0] exp_q[$];

  i2s_tx #(.SCLK_DIV(16), .SLOT_W(32), .DATA_W(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_in   (lft_in),
    .rght_in  (rght_in),
    .wrt      (wrt),
    .smpl_req (smpl_req),
    .underrun (underrun),
    .clr_undr (clr_undr),
    .I2S_sclk (I2S_sclk),
    .I2S_ws   (I2S_ws),
    .I2S_data (I2S_data)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Expected slot contents: pad bit, sample MSB first, 7 zero bits.
  function automatic logic [31:0] exp_slot(input logic [23:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  // ---------------- driver / capture tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_pair(input logic [23:0] l, input logic [23:0] r);
    lft_in = l;
    rght_in = r;
    wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n;
    for (n = 0; n < 5000; n++) begin
      if (cyc == target) break;
      @(negedge clk);
    end
    if (cyc != target) begin
      checks++; errors++;
      $display("FAIL wait_cyc: timeout at cyc %0d, target %0d", cyc, target);
    end
  endtask

  task automatic wait_req();
    int n;
    bit got = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (smpl_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_req: no smpl_req within 3000 clk (cyc %0d)", cyc);
    end
    last_req = cyc;
  endtask

  task automatic wait_sclk_rise();
    int n;
    bit seen_low = 1'b0;
    bit got = 1'b0;
    for (n = 0; n < 80; n++) begin
      @(negedge clk);
      if (I2S_sclk !== 1'b1) seen_low = 1'b1;
      else if (seen_low) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL sclk_rise: no I2S_sclk rising edge within 80 clk (cyc %0d)", cyc);
    end
  endtask

  // Capture one frame at the 64 bit-clock rising edges following a load.
  task automatic grab_frame(output logic [31:0] ls, output logic [31:0] rs,
                            output logic [63:0] wsp);
    ls = '0; rs = '0; wsp = '0;
    for (int i = 0; i < 64; i++) begin
      wait_sclk_rise();
      if (i < 32) ls[31-i] = I2S_data;
      else        rs[63-i] = I2S_data;
      wsp[63-i] = I2S_ws;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic check_startup();
    logic [31:0] ls, rs;
    logic [63:0] wsp;
    wait_cyc(15);
    checks++; if (I2S_sclk !== 1'b0) begin errors++; $display("FAIL start_sclk15: got %b want 0", I2S_sclk); end
    wait_cyc(16);
    checks++; if (I2S_sclk !== 1'b1) begin errors++; $display("FAIL start_sclk16: got %b want 1", I2S_sclk); end
    wait_cyc(31);
    checks++; if ({I2S_sclk, I2S_ws, smpl_req} !== 3'b110) begin
      errors++; $display("FAIL start_cyc31 {sclk,ws,req}: got %b want 110", {I2S_sclk, I2S_ws, smpl_req}); end
    wait_cyc(32);
    checks++; if ({I2S_sclk, I2S_ws, smpl_req} !== 3'b001) begin
      errors++; $display("FAIL start_cyc32 {sclk,ws,req}: got %b want 001", {I2S_sclk, I2S_ws, smpl_req}); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL start_undr_load: got %b want 0", underrun); end
    grab_frame(ls, rs, wsp);
    checks++; if ({ls, rs} !== 64'h0) begin errors++; $display("FAIL start_data_zero: got %h want 0", {ls, rs}); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL start_undr_frame: got %b want 0", underrun); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({I2S_sclk, I2S_ws, I2S_data, smpl_req, underrun} !== 5'b01000) begin
      errors++; $display("FAIL reset_outputs {sclk,ws,data,req,undr}: got %b want 01000",
                         {I2S_sclk, I2S_ws, I2S_data, smpl_req, underrun}); end
    rst_n = 1'b1;
    check_startup();
  endtask

  task automatic test_frames();
    logic [23:0] pl[5];
    logic [23:0] pr[5];
    logic [31:0] ls, rs;
    logic [63:0] wsp;
    logic [47:0] e;
    int prev;
    pl[0] = 24'hA5C3F0; pr[0] = 24'h5A0F3C;
    pl[1] = 24'h800001; pr[1] = 24'h7FFFFE;
    pl[2] = 24'hFFFFFF; pr[2] = 24'h000001;
    pl[3] = 24'h0C0C0C; pr[3] = 24'hC0C0C0;
    pl[4] = 24'h13579B; pr[4] = 24'h2468AC;
    do_reset();
    write_pair(pl[0], pr[0]);
    exp_q.push_back({pl[0], pr[0]});
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_req();
      if (i == 0) begin
        checks++; if (last_req != 32) begin errors++; $display("FAIL first_load_cyc: got %0d want 32", last_req); end
      end else begin
        checks++; if (last_req - prev != 2048) begin
          errors++; $display("FAIL req_spacing[%0d]: got %0d want 2048", i, last_req - prev); end
      end
      prev = last_req;
      write_pair(pl[i+1], pr[i+1]);
      exp_q.push_back({pl[i+1], pr[i+1]});
      grab_frame(ls, rs, wsp);
      e = exp_q.pop_front();
      checks++; if (ls !== exp_slot(e[47:24])) begin
        errors++; $display("FAIL frame_left[%0d]: got %h want %h", i, ls, exp_slot(e[47:24])); end
      checks++; if (rs !== exp_slot(e[23:0])) begin
        errors++; $display("FAIL frame_right[%0d]: got %h want %h", i, rs, exp_slot(e[23:0])); end
      if (i == 0) begin
        checks++; if (wsp !== 64'h00000000_FFFFFFFF) begin
          errors++; $display("FAIL ws_pattern: got %h want 00000000ffffffff", wsp); end
      end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL frame_undr[%0d]: got %b want 0", i, underrun); end
    end
  endtask

  task automatic test_underrun();
    logic [31:0] ls, rs;
    logic [63:0] wsp;
    logic [47:0] e;
    e = exp_q.pop_front();  // pair written last in test_frames
    wait_req();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL undr_fresh_load: got %b want 0", underrun); end
    grab_frame(ls, rs, wsp);
    checks++; if ({ls, rs} !== {exp_slot(e[47:24]), exp_slot(e[23:0])}) begin
      errors++; $display("FAIL undr_last_pair: got %h want %h", {ls, rs}, {exp_slot(e[47:24]), exp_slot(e[23:0])}); end
    wait_req();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL undr_set: got %b want 1", underrun); end
    grab_frame(ls, rs, wsp);
    checks++; if ({ls, rs} !== {exp_slot(e[47:24]), exp_slot(e[23:0])}) begin
      errors++; $display("FAIL undr_repeat: got %h want %h", {ls, rs}, {exp_slot(e[47:24]), exp_slot(e[23:0])}); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL undr_sticky: got %b want 1", underrun); end
    clr_undr = 1'b1;
    @(negedge clk);
    clr_undr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL undr_clear: got %b want 0", underrun); end
    // clear coincident with the next underrun event
    wait_cyc(last_req + 2047);
    clr_undr = 1'b1;
    wait_cyc(last_req + 2048);
    clr_undr = 1'b0;
    checks++; if ({smpl_req, underrun} !== 2'b11) begin
      errors++; $display("FAIL undr_set_beats_clr {req,undr}: got %b want 11", {smpl_req, underrun}); end
    last_req = cyc;
    exp_q.push_back(e);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ls, rs;
    logic [63:0] wsp;
    logic [47:0] e;
    e = exp_q.pop_front();
    clr_undr = 1'b1;
    @(negedge clk);
    clr_undr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b want 0", underrun); end
    write_pair(24'h0F0F0F, 24'hF0F0F0);
    grab_frame(ls, rs, wsp);
    checks++; if ({ls, rs} !== {exp_slot(e[47:24]), exp_slot(e[23:0])}) begin
      errors++; $display("FAIL b2b_retransmit: got %h want %h", {ls, rs}, {exp_slot(e[47:24]), exp_slot(e[23:0])}); end
    wait_cyc(last_req + 2047);
    lft_in = 24'h123456;
    rght_in = 24'h654321;
    wrt = 1'b1;
    wait_cyc(last_req + 2048);
    wrt = 1'b0;
    checks++; if (smpl_req !== 1'b1) begin errors++; $display("FAIL b2b_req_coincident: got %b want 1", smpl_req); end
    last_req = cyc;
    grab_frame(ls, rs, wsp);
    checks++; if ({ls, rs} !== {exp_slot(24'h0F0F0F), exp_slot(24'hF0F0F0)}) begin
      errors++; $display("FAIL b2b_old_pair: got %h want %h", {ls, rs}, {exp_slot(24'h0F0F0F), exp_slot(24'hF0F0F0)}); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_undr_old: got %b want 0", underrun); end
    wait_req();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_undr_new: got %b want 0", underrun); end
    grab_frame(ls, rs, wsp);
    checks++; if ({ls, rs} !== {exp_slot(24'h123456), exp_slot(24'h654321)}) begin
      errors++; $display("FAIL b2b_new_pair: got %h want %h", {ls, rs}, {exp_slot(24'h123456), exp_slot(24'h654321)}); end
  endtask

  task automatic test_mid_reset();
    wait_req();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL midrst_pre_undr: got %b want 1", underrun); end
    // bit_cnt=40 spans last_req+1280..+1311; right slot k=8 carries bit 16 of 654321
    wait_cyc(last_req + 1300);
    checks++; if ({I2S_sclk, I2S_ws, I2S_data} !== 3'b111) begin
      errors++; $display("FAIL midrst_pre {sclk,ws,data}: got %b want 111", {I2S_sclk, I2S_ws, I2S_data}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({I2S_sclk, I2S_ws, I2S_data, smpl_req, underrun} !== 5'b01000) begin
      errors++; $display("FAIL midrst_async {sclk,ws,data,req,undr}: got %b want 01000",
                         {I2S_sclk, I2S_ws, I2S_data, smpl_req, underrun}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_startup();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_frames();
    test_underrun();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: the source end of the I2S link that the equalizer's slave receiver consumes.
- Generates I2S_sclk and I2S_ws from the system clock.
- Serializes 24-bit left/right samples, MSB first, with standard I2S one-bit delay.
- Used as the synthesizable source inside the BT module model and for stand-alone equalizer bring-up with canned tone data.

Parameters:
SCLK_DIV, 16, clk cycles per I2S_sclk half-period (I2S_sclk = clk/(2*SCLK_DIV)); must be >= 2
SLOT_W, 32, I2S_sclk periods per channel slot
DATA_W, 24, sample width; must be < SLOT_W

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
lft_in  input  DATA_W  left sample to queue
rght_in  input  DATA_W  right sample to queue
wrt  input  1  one-clk strobe; captures lft_in/rght_in into holding register
smpl_req  output  1  one-clk pulse when the holding register is transferred to the shifters
underrun  output  1  sticky: a frame started with no fresh holding data
clr_undr  input  1  synchronous clear of underrun
I2S_sclk  output  1  bit clock
I2S_ws  output  1  word select (0 = left, 1 = right)
I2S_data  output  1  serial data

Behaviour:
- Reset (async, all flops):
  - I2S_sclk=0, I2S_ws=1, I2S_data=0, smpl_req=0, underrun=0.
  - div_cnt=0, bit_cnt=2*SLOT_W-1, holding regs=0, hold_vld=0, shifters=0.
- Reset asserted mid-frame aborts the frame immediately; there is no completion.
- Clock divider:
  - div_cnt counts 0..SCLK_DIV-1 each clk.
  - At terminal count I2S_sclk toggles and div_cnt wraps to 0.
- Falling edge (fall_evt): the clk cycle in which I2S_sclk toggles 1->0. All data-side state updates only on fall_evt.
- Receiver samples on I2S_sclk rising edge, so data is stable half a bit period on each side.
- Bit counter:
  - On each fall_evt, bit_cnt increments modulo 2*SLOT_W.
  - I2S_ws = (bit_cnt >= SLOT_W), registered, so ws changes on the falling edge.
- Data slot layout, with k = bit_cnt mod SLOT_W:
  - k=0: data=0 (trailing pad of previous slot).
  - k=1..DATA_W: data = sample[DATA_W-k], MSB first.
  - k>DATA_W: data=0.
  - Left sample is used while ws=0, right sample while ws=1.
  - Implementation: a 2*DATA_W shifter, or two DATA_W shifters indexed by k.
- Frame load (bit_cnt wraps to 0 on fall_evt):
  - Shifters load from holding regs; smpl_req pulses high that same clk.
  - If hold_vld=1: hold_vld clears.
  - If hold_vld=0: underrun sets, and the previous (or reset-zero) samples are retransmitted.
- First load occurs on the first fall_evt after reset, clk cycle 2*SCLK_DIV (cycle 32 with defaults). Flag underrun is not set on this first load.
- Frame period = 2*SLOT_W*2*SCLK_DIV clk cycles (2048 with defaults).
- Write:
  - wrt captures both inputs into holding and sets hold_vld.
  - A second wrt before load overwrites holding; the last write wins, with no error.
- wrt coincident with load:
  - Shifters take the old holding contents.
  - Holding takes the new inputs; hold_vld=1 afterwards.
  - underrun is evaluated on the old hold_vld.
- clr_undr coincident with an underrun event: set wins.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset release, no writes:
  - I2S_sclk first rises at clk 16 and first falls at clk 32.
  - I2S_ws falls at clk 32; smpl_req pulses at clk 32.
  - Data stays 0 and underrun stays 0 after the first load.
- wrt lft_in=24'hA5C3F0, rght_in=24'h5A0F3C before the first load:
  - Rising-edge samples of ws=0 slot bits k=1..24 equal A5C3F0 MSB first; k=0 and k=25..31 equal 0.
  - Right slot carries 5A0F3C with the same layout.
- Each frame, write a new pair within 10 clk after smpl_req, for 4 frames:
  - Each frame carries its own pair.
  - smpl_req spacing is exactly 2048 clk; underrun stays 0.
- Skip one write:
  - The next frame repeats the previous pair and underrun=1.
  - underrun stays 1 until clr_undr.
  - clr_undr in the same clk as a new underrun event leaves underrun=1.
- wrt in the same clk as smpl_req with 24'h123456/24'h654321:
  - The current frame sends the old holding pair.
  - The next frame sends 123456/654321.
- Assert rst_n low mid-right-slot (bit_cnt=40):
  - Outputs return to reset values asynchronously within the same clk.
  - After release, timing restarts exactly as in the first scenario.
